// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Brief    : Shared types and widths for the MEM/WB stage slice.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam int DATA_W                 = 32;
    localparam int REG_ADDR_W             = 5;
    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_wb_stage_if
// Brief    : Data-memory request/acknowledge bus between MEM stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_wb_stage_if
    import mips_mem_pkg::*;
;
    logic              Dmem_Req;
    logic              Dmem_We;
    logic [DATA_W-1:0] Dmem_Addr;
    logic [DATA_W-1:0] Dmem_Wdata;
    logic              Dmem_Ack;
    logic [DATA_W-1:0] Dmem_Rdata;

    modport master (
        output Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata,
        input  Dmem_Ack, Dmem_Rdata
    );

    modport slave (
        input  Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata,
        output Dmem_Ack, Dmem_Rdata
    );

endinterface
`default_nettype wire

// File: rtl/dmem_handshake_fsm.sv
`default_nettype none
// ============================================================================
// Module   : dmem_handshake_fsm
// Brief    : Data-memory handshake state, request/stall generation and the
//            optional WAIT timeout (macro DMEM_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_handshake_fsm
    import mips_mem_pkg::*;
(
    input  wire logic Clk,
    input  wire logic Reset_n,
    input  wire logic i_access,
    input  wire logic i_ack,
    output logic      o_req,
    output logic      o_stall,
    output logic      o_timeout
);
`ifdef DMEM_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT;

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_wait_cnt;
`endif

    mem_state_t r_state;
    logic       w_timeout;

`ifdef DMEM_TIMEOUT_EN
    // An ack in the final WAIT cycle still wins over the abort.
    assign w_timeout = (r_state == MEM_WAIT) && !i_ack && (r_wait_cnt == c_CNT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign o_req     = Reset_n & (((r_state == MEM_IDLE) & i_access) |
                                  ((r_state == MEM_WAIT) & ~w_timeout));
    assign o_stall   = o_req & ~i_ack;
    assign o_timeout = Reset_n & w_timeout;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= MEM_IDLE;
`ifdef DMEM_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    if (i_access && !i_ack) begin
                        r_state <= MEM_WAIT;
`ifdef DMEM_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                MEM_WAIT: begin
                    if (i_ack || w_timeout) begin
                        r_state <= MEM_IDLE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
                    end
`endif
                end
                default: r_state <= MEM_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_wb_stage
// Brief    : MEM stage: data-memory handshake, branch resolve, upstream stall
//            and MEM/WB register. Optional timeout via macro DMEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_wb_stage
    import mips_mem_pkg::*;
(
    input  wire logic                  Clk,
    input  wire logic                  Reset_n,
    input  wire logic                  RegWrite_MEM,
    input  wire logic                  MemtoReg_MEM,
    input  wire logic                  Branch_MEM,
    input  wire logic                  MemRead_MEM,
    input  wire logic                  MemWrite_MEM,
    input  wire logic                  Zero_MEM,
    input  wire logic [DATA_W-1:0]     Branch_Dest_MEM,
    input  wire logic [DATA_W-1:0]     ALU_Result_MEM,
    input  wire logic [DATA_W-1:0]     Write_Data_MEM,
    input  wire logic [DATA_W-1:0]     Instruction_MEM,
    input  wire logic [REG_ADDR_W-1:0] Write_Register_MEM,
    mem_access_wb_stage_if.master      dmem,
    output logic                       Stall_MEM,
    output logic                       PCSrc_MEM,
    output logic [DATA_W-1:0]          Branch_Target,
    output logic                       RegWrite_WB,
    output logic [REG_ADDR_W-1:0]      Write_Register_WB,
    output logic [DATA_W-1:0]          WB_Data,
    output logic [DATA_W-1:0]          Instruction_WB,
    output logic                       Align_Err_WB,
    output logic                       Timeout_Err_WB
);
`ifdef DMEM_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT;
`endif

    logic w_mem_op;
    logic w_misaligned;
    logic w_access;
    logic w_req;
    logic w_stall;
    logic w_timeout;
    logic w_err;

    logic                  r_regwrite_wb;
    logic [REG_ADDR_W-1:0] r_write_register_wb;
    logic [DATA_W-1:0]     r_wb_data;
    logic [DATA_W-1:0]     r_instruction_wb;
    logic                  r_align_err_wb;
    logic                  r_timeout_err_wb;

    assign w_mem_op     = MemRead_MEM | MemWrite_MEM;
    assign w_misaligned = w_mem_op & (ALU_Result_MEM[1:0] != 2'b00);
    assign w_access     = w_mem_op & ~w_misaligned;
    assign w_err        = w_misaligned | w_timeout;

`ifdef DMEM_TIMEOUT_EN
    dmem_handshake_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
`else
    dmem_handshake_fsm u_fsm (
`endif
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .i_access  (w_access),
        .i_ack     (dmem.Dmem_Ack),
        .o_req     (w_req),
        .o_stall   (w_stall),
        .o_timeout (w_timeout)
    );

    // A store wins when both MemRead and MemWrite are set.
    assign dmem.Dmem_Req   = w_req;
    assign dmem.Dmem_We    = MemWrite_MEM;
    assign dmem.Dmem_Addr  = {ALU_Result_MEM[DATA_W-1:2], 2'b00};
    assign dmem.Dmem_Wdata = Write_Data_MEM;

    assign Stall_MEM     = w_stall;
    assign PCSrc_MEM     = Branch_MEM & Zero_MEM & ~w_stall;
    assign Branch_Target = Branch_Dest_MEM;

    always_ff @(posedge Clk) begin
        if (!Reset_n || w_stall) begin
            r_regwrite_wb       <= 1'b0;
            r_write_register_wb <= '0;
            r_wb_data           <= '0;
            r_instruction_wb    <= '0;
            r_align_err_wb      <= 1'b0;
            r_timeout_err_wb    <= 1'b0;
        end else begin
            r_regwrite_wb       <= RegWrite_MEM & ~w_err;
            r_write_register_wb <= Write_Register_MEM;
            // Loads that never completed return zero rather than bus noise.
            r_wb_data           <= MemtoReg_MEM ? (w_err ? '0 : dmem.Dmem_Rdata)
                                                : ALU_Result_MEM;
            r_instruction_wb    <= Instruction_MEM;
            r_align_err_wb      <= w_misaligned;
            r_timeout_err_wb    <= w_timeout;
        end
    end

    assign RegWrite_WB       = r_regwrite_wb;
    assign Write_Register_WB = r_write_register_wb;
    assign WB_Data           = r_wb_data;
    assign Instruction_WB    = r_instruction_wb;
    assign Align_Err_WB      = r_align_err_wb;
    assign Timeout_Err_WB    = r_timeout_err_wb;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_wb_stage
// Brief    : Self-checking bench for mem_access_wb_stage against a per-
//            instruction reference model (honours DMEM_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_wb_stage;
    import mips_mem_pkg::*;

`ifdef DMEM_TIMEOUT_EN
    localparam bit c_TMO_EN = 1'b1;
`else
    localparam bit c_TMO_EN = 1'b0;
`endif
    localparam int c_TMO      = 16;
    localparam int c_MAX_CYC  = 80;

    typedef struct {
        logic        rw, m2r, br, rd, wr, zero;
        logic [31:0] bdest, alu, wdata, ins, rdata;
        logic [4:0]  wreg;
    } ex_t;

    typedef struct {
        int          n_req, n_stall, n_bubble, n_pcsrc;
        logic        pcsrc_final, we, rw, aerr, terr, hung;
        logic [31:0] addr, wdata, tgt, wbd, ins;
        logic [4:0]  wreg;
    } obs_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM;
    logic [31:0] Branch_Dest_MEM, ALU_Result_MEM, Write_Data_MEM, Instruction_MEM;
    logic [4:0]  Write_Register_MEM;
    logic        Stall_MEM, PCSrc_MEM, RegWrite_WB, Align_Err_WB, Timeout_Err_WB;
    logic [31:0] Branch_Target, WB_Data, Instruction_WB;
    logic [4:0]  Write_Register_WB;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_wb_stage_if dmem ();

    mem_access_wb_stage dut (
        .Clk                (Clk),
        .Reset_n            (Reset_n),
        .RegWrite_MEM       (RegWrite_MEM),
        .MemtoReg_MEM       (MemtoReg_MEM),
        .Branch_MEM         (Branch_MEM),
        .MemRead_MEM        (MemRead_MEM),
        .MemWrite_MEM       (MemWrite_MEM),
        .Zero_MEM           (Zero_MEM),
        .Branch_Dest_MEM    (Branch_Dest_MEM),
        .ALU_Result_MEM     (ALU_Result_MEM),
        .Write_Data_MEM     (Write_Data_MEM),
        .Instruction_MEM    (Instruction_MEM),
        .Write_Register_MEM (Write_Register_MEM),
        .dmem               (dmem.master),
        .Stall_MEM          (Stall_MEM),
        .PCSrc_MEM          (PCSrc_MEM),
        .Branch_Target      (Branch_Target),
        .RegWrite_WB        (RegWrite_WB),
        .Write_Register_WB  (Write_Register_WB),
        .WB_Data            (WB_Data),
        .Instruction_WB     (Instruction_WB),
        .Align_Err_WB       (Align_Err_WB),
        .Timeout_Err_WB     (Timeout_Err_WB)
    );

    always #5 Clk = ~Clk;

    task automatic drive(input ex_t x);
        RegWrite_MEM       = x.rw;
        MemtoReg_MEM       = x.m2r;
        Branch_MEM         = x.br;
        MemRead_MEM        = x.rd;
        MemWrite_MEM       = x.wr;
        Zero_MEM           = x.zero;
        Branch_Dest_MEM    = x.bdest;
        ALU_Result_MEM     = x.alu;
        Write_Data_MEM     = x.wdata;
        Instruction_MEM    = x.ins;
        Write_Register_MEM = x.wreg;
    endtask

    function automatic ex_t nop();
        ex_t x;
        x = '{rw: 1'b0, m2r: 1'b0, br: 1'b0, rd: 1'b0, wr: 1'b0, zero: 1'b0,
              bdest: 32'h0, alu: 32'h0, wdata: 32'h0, ins: 32'h0, rdata: 32'h0, wreg: 5'h0};
        return x;
    endfunction

    // Presents one instruction, holds it while stalled and acks the n_ack-th
    // request cycle; collects what the DUT did. Called and returns at posedge+1.
    task automatic exec(input ex_t x, input int n_ack, output obs_t o);
        bit done;
        o = '{default: 0};
        o.hung = 1'b1;
        drive(x);
        for (int c = 0; c < c_MAX_CYC; c++) begin
            dmem.Dmem_Ack   = (c == n_ack);
            dmem.Dmem_Rdata = (c == n_ack) ? x.rdata : $urandom;
            @(negedge Clk);
            if (dmem.Dmem_Req === 1'b1) begin
                if (o.n_req == 0) begin
                    o.we    = dmem.Dmem_We;
                    o.addr  = dmem.Dmem_Addr;
                    o.wdata = dmem.Dmem_Wdata;
                end
                o.n_req++;
            end
            if (Stall_MEM === 1'b1) o.n_stall++;
            if (PCSrc_MEM === 1'b1) o.n_pcsrc++;
            o.pcsrc_final = PCSrc_MEM;
            o.tgt         = Branch_Target;
            done          = (Stall_MEM !== 1'b1);
            @(posedge Clk);
            #1;
            if (!done) begin
                if (RegWrite_WB === 1'b0 && Instruction_WB === 32'h0 &&
                    Align_Err_WB === 1'b0 && Timeout_Err_WB === 1'b0) o.n_bubble++;
            end else begin
                o.rw   = RegWrite_WB;
                o.wreg = Write_Register_WB;
                o.wbd  = WB_Data;
                o.ins  = Instruction_WB;
                o.aerr = Align_Err_WB;
                o.terr = Timeout_Err_WB;
                o.hung = 1'b0;
                break;
            end
        end
        dmem.Dmem_Ack = 1'b0;
    endtask

    // What the stage should do with one instruction, from its architectural rules.
    function automatic obs_t model(input ex_t x, input int n_ack);
        obs_t e;
        bit   mem, mis, acc, timed;
        int   waits;
        e     = '{default: 0};
        mem   = x.rd | x.wr;
        mis   = mem && (x.alu % 4 != 0);
        acc   = mem && !mis;
        timed = acc && c_TMO_EN && (n_ack >= c_TMO);
        waits = !acc ? 0 : (timed ? c_TMO : n_ack);
        e.n_stall     = waits;
        e.n_bubble    = waits;
        e.n_req       = !acc ? 0 : (timed ? c_TMO : waits + 1);
        e.we          = x.wr;
        e.addr        = x.alu - (x.alu % 4);
        e.wdata       = x.wdata;
        e.pcsrc_final = x.br & x.zero;
        e.n_pcsrc     = (x.br & x.zero) ? 1 : 0;
        e.tgt         = x.bdest;
        e.rw          = x.rw && !mis && !timed;
        e.wreg        = x.wreg;
        e.ins         = x.ins;
        e.wbd         = x.m2r ? ((mis || timed) ? 32'h0 : x.rdata) : x.alu;
        e.aerr        = mis;
        e.terr        = timed;
        return e;
    endfunction

    task automatic test_reset();
        ex_t x;
        x = nop();
        x.rd = 1'b1; x.rw = 1'b1; x.m2r = 1'b1; x.alu = 32'h200; x.ins = 32'hFFFF_FFFF; x.wreg = 5'd9;
        Reset_n = 1'b0;
        drive(x);
        dmem.Dmem_Ack   = 1'b0;
        dmem.Dmem_Rdata = 32'h0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_checks++; if (dmem.Dmem_Req !== 1'b0) $display("FAIL rst_req got %b exp 0", dmem.Dmem_Req); else n_pass++;
        n_checks++; if (Stall_MEM !== 1'b0) $display("FAIL rst_stall got %b exp 0", Stall_MEM); else n_pass++;
        n_checks++; if ({RegWrite_WB, Write_Register_WB, WB_Data, Instruction_WB, Align_Err_WB, Timeout_Err_WB} !== 72'h0)
            $display("FAIL rst_wb_regs got rw=%b wreg=%h wbd=%h ins=%h ae=%b te=%b exp all 0",
                     RegWrite_WB, Write_Register_WB, WB_Data, Instruction_WB, Align_Err_WB, Timeout_Err_WB);
        else n_pass++;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        drive(nop());
    endtask

    task automatic test_alu_op();
        ex_t x; obs_t o;
        x = nop();
        x.rw = 1'b1; x.alu = 32'h1234; x.wreg = 5'd3; x.ins = 32'h0123_4020;
        exec(x, 0, o);   // stray ack with no request must be ignored
        n_checks++; if (o.n_stall !== 0) $display("FAIL alu_stall got %0d exp 0", o.n_stall); else n_pass++;
        n_checks++; if (o.n_req !== 0) $display("FAIL alu_req got %0d exp 0", o.n_req); else n_pass++;
        n_checks++; if (o.rw !== 1'b1) $display("FAIL alu_rw got %b exp 1", o.rw); else n_pass++;
        n_checks++; if (o.wbd !== 32'h1234) $display("FAIL alu_wbd got %h exp 00001234", o.wbd); else n_pass++;
        n_checks++; if (o.wreg !== 5'd3 || o.ins !== 32'h0123_4020) $display("FAIL alu_pass got wreg=%0d ins=%h exp 3 01234020", o.wreg, o.ins); else n_pass++;
    endtask

    task automatic test_load_wait();
        ex_t x; obs_t o;
        x = nop();
        x.rw = 1'b1; x.m2r = 1'b1; x.rd = 1'b1; x.alu = 32'h100; x.rdata = 32'hDEAD_BEEF; x.wreg = 5'd8; x.ins = 32'h8C08_0100;
        exec(x, 3, o);
        n_checks++; if (o.n_stall !== 3) $display("FAIL load_stall got %0d exp 3", o.n_stall); else n_pass++;
        n_checks++; if (o.n_bubble !== 3) $display("FAIL load_bubbles got %0d exp 3", o.n_bubble); else n_pass++;
        n_checks++; if (o.addr !== 32'h100 || o.we !== 1'b0) $display("FAIL load_bus got addr=%h we=%b exp 00000100 0", o.addr, o.we); else n_pass++;
        n_checks++; if (o.rw !== 1'b1 || o.wbd !== 32'hDEAD_BEEF) $display("FAIL load_wb got rw=%b wbd=%h exp 1 deadbeef", o.rw, o.wbd); else n_pass++;
    endtask

    task automatic test_store_immediate();
        ex_t x; obs_t o;
        x = nop();
        x.wr = 1'b1; x.rd = 1'b1; x.alu = 32'h104; x.wdata = 32'hA5A5_A5A5; x.ins = 32'hAC00_0104;
        exec(x, 0, o);
        n_checks++; if (o.n_stall !== 0 || o.n_req !== 1) $display("FAIL store_hs got stall=%0d req=%0d exp 0 1", o.n_stall, o.n_req); else n_pass++;
        n_checks++; if (o.we !== 1'b1 || o.addr !== 32'h104 || o.wdata !== 32'hA5A5_A5A5)
            $display("FAIL store_bus got we=%b addr=%h wdata=%h exp 1 00000104 a5a5a5a5", o.we, o.addr, o.wdata);
        else n_pass++;
        n_checks++; if (o.rw !== 1'b0) $display("FAIL store_rw got %b exp 0", o.rw); else n_pass++;
    endtask

    task automatic test_misaligned();
        ex_t x; obs_t o;
        x = nop();
        x.rw = 1'b1; x.m2r = 1'b1; x.rd = 1'b1; x.alu = 32'h102; x.rdata = 32'h5555_5555; x.wreg = 5'd4; x.ins = 32'h8C04_0102;
        exec(x, 0, o);
        n_checks++; if (o.n_req !== 0) $display("FAIL mis_req got %0d exp 0", o.n_req); else n_pass++;
        n_checks++; if (o.aerr !== 1'b1 || o.rw !== 1'b0 || o.wbd !== 32'h0)
            $display("FAIL mis_wb got ae=%b rw=%b wbd=%h exp 1 0 00000000", o.aerr, o.rw, o.wbd);
        else n_pass++;
        exec(nop(), 1, o);
        n_checks++; if (o.aerr !== 1'b0) $display("FAIL mis_pulse got %b exp 0", o.aerr); else n_pass++;
    endtask

    task automatic test_branch_stall();
        ex_t x; obs_t o;
        x = nop();
        x.rd = 1'b1; x.m2r = 1'b1; x.rw = 1'b1; x.alu = 32'h40; x.rdata = 32'h77; x.br = 1'b1; x.zero = 1'b1;
        x.bdest = 32'h0000_4000; x.ins = 32'h1000_0010;
        exec(x, 2, o);
        n_checks++; if (o.n_pcsrc !== 1 || o.pcsrc_final !== 1'b1)
            $display("FAIL br_pcsrc got cycles=%0d final=%b exp 1 1", o.n_pcsrc, o.pcsrc_final);
        else n_pass++;
        n_checks++; if (o.tgt !== 32'h0000_4000) $display("FAIL br_target got %h exp 00004000", o.tgt); else n_pass++;
        exec(nop(), 0, o);
        n_checks++; if (o.n_pcsrc !== 0) $display("FAIL br_once got %0d exp 0", o.n_pcsrc); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        ex_t x; obs_t o;
        x = nop();
        x.rd = 1'b1; x.rw = 1'b1; x.m2r = 1'b1; x.alu = 32'h300; x.ins = 32'h8C01_0300; x.wreg = 5'd1;
        drive(x);
        dmem.Dmem_Ack = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        @(negedge Clk);
        n_checks++; if (dmem.Dmem_Req !== 1'b0 || Stall_MEM !== 1'b0)
            $display("FAIL rstw_comb got req=%b stall=%b exp 0 0", dmem.Dmem_Req, Stall_MEM);
        else n_pass++;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        drive(nop());
        dmem.Dmem_Ack   = 1'b1;
        dmem.Dmem_Rdata = 32'hBAD0_BAD0;
        @(negedge Clk);
        n_checks++; if (dmem.Dmem_Req !== 1'b0 || Stall_MEM !== 1'b0)
            $display("FAIL rstw_late_ack got req=%b stall=%b exp 0 0", dmem.Dmem_Req, Stall_MEM);
        else n_pass++;
        @(posedge Clk);
        #1;
        dmem.Dmem_Ack = 1'b0;
        n_checks++; if (RegWrite_WB !== 1'b0 || Instruction_WB !== 32'h0 || WB_Data !== 32'h0)
            $display("FAIL rstw_wb got rw=%b ins=%h wbd=%h exp 0 0 0", RegWrite_WB, Instruction_WB, WB_Data);
        else n_pass++;
        x.alu = 32'h304; x.rdata = 32'h1111_2222;
        exec(x, 1, o);
        n_checks++; if (o.n_stall !== 1 || o.wbd !== 32'h1111_2222)
            $display("FAIL rstw_recover got stall=%0d wbd=%h exp 1 11112222", o.n_stall, o.wbd);
        else n_pass++;
    endtask

    task automatic test_long_wait();
        ex_t x; obs_t o, e;
        int  n;
        x = nop();
        x.rd = 1'b1; x.rw = 1'b1; x.m2r = 1'b1; x.alu = 32'h500; x.rdata = 32'hCAFE_F00D; x.ins = 32'h8C02_0500; x.wreg = 5'd2;
        n = c_TMO_EN ? 1000 : 20;
        e = model(x, n);
        exec(x, n, o);
        n_checks++; if (o.hung !== 1'b0) $display("FAIL long_hung got %b exp 0", o.hung); else n_pass++;
        n_checks++; if (o.n_stall !== e.n_stall || o.n_req !== e.n_req)
            $display("FAIL long_hs got stall=%0d req=%0d exp %0d %0d", o.n_stall, o.n_req, e.n_stall, e.n_req);
        else n_pass++;
        n_checks++; if (o.terr !== e.terr || o.rw !== e.rw || o.wbd !== e.wbd)
            $display("FAIL long_wb got te=%b rw=%b wbd=%h exp %b %b %h", o.terr, o.rw, o.wbd, e.terr, e.rw, e.wbd);
        else n_pass++;
        exec(nop(), 0, o);
        n_checks++; if (o.terr !== 1'b0) $display("FAIL long_pulse got %b exp 0", o.terr); else n_pass++;
    endtask

    task automatic test_random_stream();
        ex_t x; obs_t o, e;
        int  n, kind;
        for (int i = 0; i < 40; i++) begin
            kind    = $urandom_range(0, 4);
            x       = nop();
            x.rw    = $urandom_range(0, 1);
            x.br    = $urandom_range(0, 1);
            x.zero  = $urandom_range(0, 1);
            x.bdest = $urandom;
            x.alu   = $urandom;
            x.wdata = $urandom;
            x.ins   = $urandom;
            x.rdata = $urandom;
            x.wreg  = 5'($urandom_range(0, 31));
            x.rd    = (kind == 1 || kind == 3);
            x.wr    = (kind == 2 || kind == 3);
            x.m2r   = x.rd && !x.wr;
            if (kind != 4 && $urandom_range(0, 3) != 0) x.alu[1:0] = 2'b00;
            n = $urandom_range(0, 4);
            e = model(x, n);
            exec(x, n, o);
            n_checks++; if (o.hung !== 1'b0 || o.n_stall !== e.n_stall || o.n_bubble !== e.n_bubble || o.n_req !== e.n_req)
                $display("FAIL rnd%0d_hs got hung=%b stall=%0d bub=%0d req=%0d exp 0 %0d %0d %0d",
                         i, o.hung, o.n_stall, o.n_bubble, o.n_req, e.n_stall, e.n_bubble, e.n_req);
            else n_pass++;
            if (e.n_req > 0) begin
                n_checks++; if (o.we !== e.we || o.addr !== e.addr || o.wdata !== e.wdata)
                    $display("FAIL rnd%0d_bus got we=%b addr=%h wd=%h exp %b %h %h", i, o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
                else n_pass++;
            end
            n_checks++; if (o.rw !== e.rw || o.wreg !== e.wreg || o.ins !== e.ins || o.aerr !== e.aerr || o.terr !== e.terr)
                $display("FAIL rnd%0d_wbctl got rw=%b wreg=%0d ins=%h ae=%b te=%b exp %b %0d %h %b %b",
                         i, o.rw, o.wreg, o.ins, o.aerr, o.terr, e.rw, e.wreg, e.ins, e.aerr, e.terr);
            else n_pass++;
            if (e.rw || e.aerr) begin
                n_checks++; if (o.wbd !== e.wbd) $display("FAIL rnd%0d_wbd got %h exp %h", i, o.wbd, e.wbd); else n_pass++;
            end
            n_checks++; if (o.n_pcsrc !== e.n_pcsrc || o.pcsrc_final !== e.pcsrc_final || o.tgt !== e.tgt)
                $display("FAIL rnd%0d_br got n=%0d fin=%b tgt=%h exp %0d %b %h",
                         i, o.n_pcsrc, o.pcsrc_final, o.tgt, e.n_pcsrc, e.pcsrc_final, e.tgt);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_wait();
        test_store_immediate();
        test_misaligned();
        test_branch_stall();
        test_reset_in_wait();
        test_long_wait();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
